// File: rtl/serial_debug_pkg.sv
// serial_debug_pkg: shared word-field layout and FSM states for serial_debug_arbiter
package serial_debug_pkg;
  localparam int ID_W    = 4;
  localparam int SEQ_W   = 4;
  localparam int ID_MSB  = 1;
  localparam int ID_LSB  = 4;
  localparam int SEQ_MSB = 5;
  localparam int SEQ_LSB = 8;
  typedef enum logic [0:0] {IDLE = 1'b0, PUBLISH = 1'b1} state_t;
endpackage

// File: rtl/serial_debug_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, lowest offset from ptr wins
module rr_arbiter #(
  parameter int CLIENTS = 4,
  parameter int PW = $clog2(CLIENTS)
) (
  input  logic [CLIENTS-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [CLIENTS-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               any
);
  // scan from farthest offset down so the nearest requester past ptr overwrites
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % CLIENTS]) begin
        idx = PW'((int'(ptr) + i) % CLIENTS);
        any = 1'b1;
      end
    end
    gnt = any ? CLIENTS'(1) << idx : '0;
  end
endmodule

// File: rtl/serial_debug_arbiter.sv
// serial_debug_arbiter: shares one serial_debug node word among several local clients
module serial_debug_arbiter
  import serial_debug_pkg::*;
#(
  parameter int BITS    = 128,
  parameter int CLIENTS = 4,
  parameter int DWELL   = 1024,
  parameter int PAYLOAD = BITS - 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CLIENTS-1:0]         req_valid,
  input  logic [CLIENTS*PAYLOAD-1:0] req_data,
  output logic [CLIENTS-1:0]         req_ready,
  output logic [CLIENTS-1:0]         rsp_valid,
  output logic [PAYLOAD-1:0]         rsp_data,
  output logic [15:0]                drop_cnt,
  output logic [BITS-1:0]            debug_outgoing_data,
  input  logic                       debug_incoming_tgl,
  input  logic [BITS-1:0]            debug_incoming_data
);
  localparam int PW = $clog2(CLIENTS);
  localparam int CW = $clog2(DWELL);
  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gidx;
  logic [CLIENTS-1:0] gnt;
  logic              any;
  logic              grant;
  logic [SEQ_W-1:0]  seq;
  logic [CW-1:0]     cnt;
  logic              tgl_prev;
  logic [ID_W-1:0]   in_id;
  logic              unused_seq;

  rr_arbiter #(.CLIENTS(CLIENTS)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gidx),
    .any(any)
  );

  assign grant      = rst_n && state == IDLE && any;
  assign req_ready  = grant ? gnt : '0;
  assign in_id      = debug_incoming_data[BITS-ID_MSB:BITS-ID_LSB];
  assign unused_seq = ^debug_incoming_data[BITS-SEQ_MSB:BITS-SEQ_LSB];

  // outbound: grant in IDLE, then hold the published word for DWELL cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      seq                 <= '0;
      cnt                 <= '0;
      debug_outgoing_data <= '0;
    end else if (state == IDLE) begin
      if (any) begin
        debug_outgoing_data <= {ID_W'(gidx), seq, req_data[int'(gidx)*PAYLOAD +: PAYLOAD]};
        seq                 <= seq + 1'b1;
        rr_ptr              <= PW'((int'(gidx) + 1) % CLIENTS);
        cnt                 <= CW'(DWELL - 1);
        state               <= PUBLISH;
      end
    end else if (cnt == '0) begin
      state <= IDLE;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // inbound: on each toggle change route the payload or count an unknown destination
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgl_prev  <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      drop_cnt  <= '0;
    end else begin
      rsp_valid <= '0;
      if (debug_incoming_tgl != tgl_prev) begin
        tgl_prev <= debug_incoming_tgl;
        if (int'(in_id) < CLIENTS) begin
          rsp_valid <= CLIENTS'(1) << in_id;
          rsp_data  <= debug_incoming_data[PAYLOAD-1:0];
        end else if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_debug_arbiter.sv
// tb_serial_debug_arbiter: directed + random checks against a cycle-count reference model
module tb_serial_debug_arbiter;
  localparam int B = 32;
  localparam int C = 4;
  localparam int D = 8;
  localparam int P = B - 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [C-1:0]   req_valid;
  logic [C*P-1:0] req_data;
  logic [C-1:0]   req_ready;
  logic [C-1:0]   rsp_valid;
  logic [P-1:0]   rsp_data;
  logic [15:0]    drop_cnt;
  logic [B-1:0]   dout;
  logic           tgl;
  logic [B-1:0]   din;

  serial_debug_arbiter #(.BITS(B), .CLIENTS(C), .DWELL(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .drop_cnt(drop_cnt),
    .debug_outgoing_data(dout),
    .debug_incoming_tgl(tgl),
    .debug_incoming_data(din)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int free_at = 0;
  int m_ptr = 0;
  logic [3:0]   m_seq = '0;
  logic         m_tgl = 1'b0;
  logic [B-1:0] e_out = '0;
  logic [C-1:0] e_rv = '0;
  logic [P-1:0] e_rd = '0;
  int           e_drop = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // one clock: check comb grant, advance model, then check registered outputs
  task automatic tick();
    logic [C-1:0] e_ready;
    logic [B-1:0] n_out;
    logic [C-1:0] n_rv;
    logic [P-1:0] n_rd;
    int           n_drop;
    int           g;
    #1;
    e_ready = '0;
    n_out = e_out;
    n_rv = '0;
    n_rd = e_rd;
    n_drop = e_drop;
    if (!rst_n) begin
      n_out = '0;
      n_rd = '0;
      n_drop = 0;
      m_ptr = 0;
      m_seq = '0;
      m_tgl = 1'b0;
      free_at = cyc + 1;
    end else begin
      g = -1;
      if (cyc >= free_at)
        for (int k = 0; k < C; k++)
          if (g < 0 && req_valid[(m_ptr + k) % C]) g = (m_ptr + k) % C;
      if (g >= 0) begin
        e_ready[g] = 1'b1;
        n_out = {4'(g), m_seq, req_data[g*P +: P]};
        m_seq = m_seq + 4'd1;
        m_ptr = (g + 1) % C;
        free_at = cyc + D + 1;
      end
      if (tgl != m_tgl) begin
        m_tgl = tgl;
        if (int'(din[B-1 -: 4]) < C) begin
          n_rv[din[B-1 -: 4]] = 1'b1;
          n_rd = din[P-1:0];
        end else begin
          n_drop = (e_drop < 65535) ? e_drop + 1 : 65535;
        end
      end
    end
    check("req_ready", 64'(req_ready), 64'(e_ready));
    @(posedge clk);
    cyc++;
    e_out = n_out;
    e_rv = n_rv;
    e_rd = n_rd;
    e_drop = n_drop;
    @(negedge clk);
    check("debug_outgoing_data", 64'(dout), 64'(e_out));
    check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    check("rsp_data", 64'(rsp_data), 64'(e_rd));
    check("drop_cnt", 64'(drop_cnt), 64'(e_drop));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    tgl = 1'b0;
    din = '0;
    @(negedge clk);
    tick();
    tick();
    check("reset_out", 64'(dout), 64'h0);
    rst_n = 1'b1;
    tick();

    req_valid = 4'b0010;
    req_data[1*P +: P] = 24'hABC;
    tick();
    req_valid = '0;
    for (int i = 0; i < D; i++) begin
      tick();
      check("single_word", 64'(dout), 64'({4'h1, 4'h0, 24'hABC}));
    end
    tick();

    req_valid = 4'b1111;
    for (int i = 0; i < C; i++) req_data[i*P +: P] = P'($urandom);
    for (int i = 0; i < 18 * (D + 1); i++) tick();
    req_valid = '0;
    for (int i = 0; i < D + 2; i++) tick();

    din = {4'h2, 4'h7, 24'h55};
    tgl = 1'b1;
    tick();
    tick();
    check("inbound_data", 64'(rsp_data), 64'h55);

    din = {4'hF, 4'h0, 24'h123};
    tgl = 1'b0;
    tick();
    check("unknown_drop", 64'(drop_cnt), 64'd1);
    tick();

    req_valid = 4'b0001;
    din = {4'h3, 4'h1, 24'h777};
    tgl = 1'b1;
    tick();
    check("simul_rsp", 64'(rsp_valid), 64'b1000);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    check("mid_reset_out", 64'(dout), 64'h0);
    rst_n = 1'b1;
    tick();
    req_valid = '0;
    for (int i = 0; i < D + 2; i++) tick();

    for (int i = 0; i < 600; i++) begin
      req_valid = C'($urandom);
      for (int k = 0; k < C; k++) req_data[k*P +: P] = P'($urandom);
      if ($urandom_range(2) == 0) begin
        din = B'($urandom);
        tgl = ~tgl;
      end
      tick();
    end

    req_valid = '0;
    din = {4'hE, 4'h0, 24'h0};
    for (int i = 0; i < 65540; i++) begin
      tgl = ~tgl;
      tick();
    end
    check("drop_saturated", 64'(drop_cnt), 64'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_debug_arbiter.md
Name: serial_debug_arbiter

Overview:
Shares one serial_debug node's outgoing/incoming word between CLIENTS local requesters.
- Outbound: round-robin grants client publishes into debug_outgoing_data, holding each for DWELL cycles so the chain can sample it.
- Inbound: detects debug_incoming_tgl edges, decodes the destination tag and routes the payload to one client.
- Sits between user logic and a serial_debug instance in any top that has more debug sources than chain nodes.

Parameters:
- BITS, 128, chain word width; must match the attached serial_debug.
- CLIENTS, 4, number of requesters; range 2..16.
- DWELL, 1024, cycles each granted word is held on debug_outgoing_data; minimum 2.
- PAYLOAD, BITS-8, derived; client payload width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  CLIENTS  per-client publish request.
- req_data  in  CLIENTS*PAYLOAD  per-client payload; client i occupies slice [i*PAYLOAD +: PAYLOAD].
- req_ready  out  CLIENTS  one-hot accept pulse.
- rsp_valid  out  CLIENTS  one-hot delivery pulse.
- rsp_data  out  PAYLOAD  delivered payload, shared by all clients.
- drop_cnt  out  16  count of inbound words with unknown destination; saturating.
- debug_outgoing_data  out  BITS  to the node's debug_outgoing_data.
- debug_incoming_tgl  in  1  from the node.
- debug_incoming_data  in  BITS  from the node.

Behaviour:
Word format, both directions:
- [BITS-1:BITS-4] = client id.
- [BITS-5:BITS-8] = 4-bit sequence number.
- [PAYLOAD-1:0] = payload.

Reset (rst_n low at a clk edge):
- debug_outgoing_data=0, req_ready=0, rsp_valid=0, rsp_data=0, drop_cnt=0.
- rr_ptr=0, seq=0, tgl_prev=0, state=IDLE, dwell counter=0.
- Reset mid-PUBLISH abandons the dwell immediately; no ready pulse is reissued.

FSM, outbound:
- IDLE:
  - Search req_valid starting at rr_ptr and wrapping modulo CLIENTS.
  - If client g is found, in that same cycle: req_ready[g]=1 for exactly one cycle; next cycle debug_outgoing_data={g[3:0],seq,req_data[g]}.
  - Also on a grant: seq<=seq+1 (wraps 15->0), rr_ptr<=(g+1) mod CLIENTS, cnt<=DWELL-1, go to PUBLISH.
  - If no request, stay in IDLE and debug_outgoing_data holds its last value.
- PUBLISH:
  - Decrement cnt each cycle; req_ready stays 0.
  - When cnt==0, go to IDLE; the next grant can issue in that IDLE cycle.
  - Grant-to-grant spacing is therefore DWELL+1 cycles under continuous load.
- Fairness: with all clients requesting, grants are 0,1,2,...,CLIENTS-1,0,...
- A client dropping req_valid before its grant is never granted; no stale latch is kept.

Inbound (independent of the FSM, runs in every state):
- Each cycle: if debug_incoming_tgl != tgl_prev, then tgl_prev<=debug_incoming_tgl and decode id=debug_incoming_data[BITS-1:BITS-4].
- If id < CLIENTS: next cycle rsp_valid[id]=1 for one cycle and rsp_data=debug_incoming_data[PAYLOAD-1:0]. Latency is 1 cycle from the toggle change.
- Otherwise: drop_cnt increments, saturating at 16'hFFFF, and rsp_valid stays 0.
- rsp_data holds its value between deliveries.
- No backpressure on rsp; a client must accept in the pulse cycle.
- Inbound and outbound events in the same cycle do not interact.

Decomposition:
- Shared package serial_debug_pkg:
  - ID_MSB, ID_LSB, SEQ_MSB, SEQ_LSB field offsets, expressed relative to BITS.
  - the 4-bit id and seq widths.
  - the FSM state enum {IDLE, PUBLISH}.
- One natural sub-module: rr_arbiter, a parameterized CLIENTS-wide round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: grant one-hot, grant index, any.
  - Purely combinational; rr_ptr is registered in the parent.

Test Plan:
- Single request (CLIENTS=4, DWELL=8): req_valid=0010, req_data[1]=0xABC -> req_ready=0010 for one cycle; debug_outgoing_data={4'h1,4'h0,0xABC} stable for 8 cycles; seq becomes 1.
- All four request continuously (DWELL=8) -> req_ready pulses at 0001,0010,0100,1000,0001, spaced 9 cycles apart; seq fields in the words are 0,1,2,3,4; the word held 16 grants later carries seq 0 again (wrap).
- Inbound: toggle debug_incoming_tgl 0->1 with data {4'h2,4'h7,payload 0x55} -> next cycle rsp_valid=0100 and rsp_data=0x55; drop_cnt unchanged.
- Unknown id: toggle with id=4'hF (CLIENTS=4) -> no rsp_valid and drop_cnt 0->1; preload drop_cnt at 16'hFFFF, repeat -> stays 16'hFFFF.
- Reset mid-PUBLISH: assert rst_n=0 for one cycle at cnt=3 -> next cycle all outputs 0, state IDLE, seq=0; a pending req_valid=0001 is granted on the first cycle after rst_n returns high.
- Simultaneous grant and inbound toggle in the same cycle -> req_ready pulse and a rsp_valid one cycle later both occur; neither is lost or delayed.
